// File: rtl/sm_fv_pingpong_bank.sv
// Ping-pong feature-value line bank: one buffer captures a streamed FV iteration while
// the other serves 1-cycle-latency reads to the vertex PE.
//
// state  | meaning
// F_IDLE | waiting for in_sos
// F_FILL | capturing beats into the fill buffer
// F_DROP | stream arrived with no free buffer; discarding until in_eos
module sm_fv_pingpong_bank #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 6,
  parameter int A_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_sos,
  input  logic              in_eos,
  input  logic [A_W-1:0]    in_A,
  input  logic [DATA_W-1:0] in_data,
  output logic              fill_avail,
  output logic              rd_ready,
  output logic [ADDR_W:0]   rd_len,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_release,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err_overflow,
  output logic              err_addr
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_FILL = 2'd1,
    F_DROP = 2'd2
  } fill_state_t;

  fill_state_t       state, state_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt, beat_num;
  logic              wr_en, complete, overflow;
  logic              fill_ptr, serve_ptr;
  logic [1:0]        full, full_nxt;
  logic [CNT_W-1:0]  len [2];
  logic [DATA_W-1:0] mem [2*DEPTH];
  logic              release_ok, rd_accept, addr_hi_bad;

  assign addr_hi_bad = |in_A[A_W-1:ADDR_W];
  assign release_ok  = rd_release & full[serve_ptr];
  assign rd_accept   = rd_req & full[serve_ptr];

  assign fill_avail = ~full[fill_ptr];
  assign rd_ready   = full[serve_ptr];
  assign rd_len     = len[serve_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= F_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    complete  = 1'b0;
    overflow  = 1'b0;
    beat_num  = beat_cnt;
    unique case (state)
      F_IDLE: begin
        if (in_sos) begin
          if (!full[fill_ptr]) begin
            wr_en    = 1'b1;
            beat_num = CNT_W'(1);
            if (in_eos) complete  = 1'b1;
            else        state_nxt = F_FILL;
          end else begin
            overflow = 1'b1;
            if (!in_eos) state_nxt = F_DROP;
          end
        end
      end
      F_FILL: begin
        wr_en = 1'b1;
        // a fresh sos without a prior eos abandons the partial stream in place
        if (in_sos)                    beat_num = CNT_W'(1);
        else if (beat_cnt != CNT_MAX)  beat_num = beat_cnt + CNT_W'(1);
        if (in_eos) begin
          complete  = 1'b1;
          state_nxt = F_IDLE;
        end
      end
      F_DROP: begin
        if (in_eos) state_nxt = F_IDLE;
      end
      default: state_nxt = F_IDLE;
    endcase
    beat_cnt_nxt = complete ? '0 : beat_num;
  end

  // fill and release always target different buffers, so both may land together
  always_comb begin
    full_nxt = full;
    if (complete)   full_nxt[fill_ptr]  = 1'b1;
    if (release_ok) full_nxt[serve_ptr] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt     <= '0;
      full         <= '0;
      fill_ptr     <= 1'b0;
      serve_ptr    <= 1'b0;
      len[0]       <= '0;
      len[1]       <= '0;
      err_overflow <= 1'b0;
      err_addr     <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else begin
      beat_cnt <= beat_cnt_nxt;
      full     <= full_nxt;
      if (complete) begin
        len[fill_ptr] <= beat_num;
        fill_ptr      <= ~fill_ptr;
      end
      if (release_ok)          serve_ptr    <= ~serve_ptr;
      if (overflow)            err_overflow <= 1'b1;
      if (wr_en & addr_hi_bad) err_addr     <= 1'b1;
      rd_valid <= rd_accept;
      if (rd_accept) begin
        if ({1'b0, rd_addr} >= rd_len) rd_data <= '0;
        else                           rd_data <= mem[{serve_ptr, rd_addr}];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{fill_ptr, in_A[ADDR_W-1:0]}] <= in_data;
  end

endmodule

// File: tb/tb_sm_fv_pingpong_bank.sv
// Scoreboard bench for sm_fv_pingpong_bank: a two-entry FIFO of completed streams models
// the bank; read responses are queued at issue and checked by an independent monitor.
module tb_sm_fv_pingpong_bank;
  localparam int DW = 128;
  localparam int AW = 6;
  localparam int XW = 8;
  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_DROP = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_sos = 1'b0, in_eos = 1'b0;
  logic [XW-1:0] in_A = '0;
  logic [DW-1:0] in_data = '0;
  logic          fill_avail, rd_ready, rd_valid, err_overflow, err_addr;
  logic [AW:0]   rd_len;
  logic          rd_req = 1'b0, rd_release = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;

  always #5 clk = ~clk;

  sm_fv_pingpong_bank #(.DATA_W(DW), .ADDR_W(AW), .A_W(XW)) dut (
    .clk(clk), .reset(reset), .in_sos(in_sos), .in_eos(in_eos), .in_A(in_A),
    .in_data(in_data), .fill_avail(fill_avail), .rd_ready(rd_ready), .rd_len(rd_len),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_release(rd_release), .rd_valid(rd_valid),
    .rd_data(rd_data), .err_overflow(err_overflow), .err_addr(err_addr)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    bit            dc;
  } exp_t;
  exp_t sb[$];

  // reference model: FIFO of up to two completed streams, each a sparse line image
  int            qcnt, head, mst, mcnt, mslot;
  bit            m_ovf, m_eaddr;
  int            qlen [2];
  logic [DW-1:0] qd [2][64];
  bit            qv [2][64];

  task automatic model_reset();
    qcnt = 0; head = 0; mst = M_IDLE; mcnt = 0; mslot = 0;
    m_ovf = 0; m_eaddr = 0; qlen[0] = 0; qlen[1] = 0;
  endtask

  task automatic model_step(input bit sos, input bit eos, input logic [XW-1:0] a,
                            input logic [DW-1:0] d, input bit req, input logic [AW-1:0] addr,
                            input bit rel);
    exp_t e;
    bit   done = 0;
    bit   wr = 0;
    bit   no_room = (qcnt == 2);
    if (req && qcnt > 0) begin
      if (int'(addr) >= qlen[head]) begin
        e.data = '0; e.dc = 0;
      end else begin
        e.data = qd[head][addr]; e.dc = !qv[head][addr];
      end
      sb.push_back(e);
    end
    case (mst)
      M_IDLE: if (sos) begin
        if (!no_room) begin
          mslot = (head + qcnt) % 2;
          wr = 1;
          if (eos) done = 1; else mst = M_FILL;
        end else begin
          m_ovf = 1;
          if (!eos) mst = M_DROP;
        end
      end
      M_FILL: begin
        wr = 1;
        if (eos) begin done = 1; mst = M_IDLE; end
      end
      default: if (eos) mst = M_IDLE;
    endcase
    if (wr) begin
      if (sos) begin
        for (int j = 0; j < 64; j++) qv[mslot][j] = 0;
        mcnt = 0;
      end
      if (mcnt < 64) mcnt++;
      qd[mslot][a % 64] = d;
      qv[mslot][a % 64] = 1;
      if (a >= 64) m_eaddr = 1;
    end
    if (done) qlen[mslot] = mcnt;
    if (rel && qcnt > 0) begin head = 1 - head; qcnt--; end
    if (done) qcnt++;
  endtask

  task automatic check_status();
    chk("fill_avail", fill_avail, qcnt < 2);
    chk("rd_ready", rd_ready, qcnt > 0);
    if (qcnt > 0) chk("rd_len", rd_len, qlen[head]);
    chk("err_overflow", err_overflow, m_ovf);
    chk("err_addr", err_addr, m_eaddr);
  endtask

  task automatic step(input bit sos, input bit eos, input logic [XW-1:0] a,
                      input logic [DW-1:0] d, input bit req, input logic [AW-1:0] addr,
                      input bit rel);
    @(negedge clk);
    check_status();
    in_sos = sos; in_eos = eos; in_A = a; in_data = d;
    rd_req = req; rd_addr = addr; rd_release = rel;
    model_step(sos, eos, a, d, req, addr, rel);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, 0);
  endtask

  task automatic rd(input logic [AW-1:0] addr);
    step(0, 0, '0, '0, 1, addr, 0);
  endtask

  task automatic release_all();
    step(0, 0, '0, '0, 0, '0, 1);
    step(0, 0, '0, '0, 0, '0, 1);
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_stream(input int n, input bit seq, input bit rnd);
    logic [XW-1:0] a;
    logic [DW-1:0] d;
    bit            sos;
    for (int i = 0; i < n; i++) begin
      sos = (i == 0);
      if (seq) begin
        a = XW'(i); d = DW'(i * 17);
      end else begin
        a = XW'($urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) a = a | 8'h40;
        d = rand_data();
        if (i > 0 && $urandom_range(0, 30) == 0) sos = 1;
      end
      if (rnd)
        step(sos, i == n - 1, a, d, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)),
             $urandom_range(0, 15) == 0);
      else
        step(sos, i == n - 1, a, d, 0, '0, 0);
    end
  endtask

  bit mon_en = 0;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_sos = 0; in_eos = 0; in_A = '0; in_data = '0;
    rd_req = 0; rd_addr = '0; rd_release = 0;
    sb.delete();
    model_reset();
    mon_en = 1;
    repeat (2) @(negedge clk);
    chk("rst_fill_avail", fill_avail, 1'b1);
    chk("rst_rd_ready", rd_ready, 1'b0);
    chk("rst_rd_len", rd_len, '0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_err_overflow", err_overflow, 1'b0);
    chk("rst_err_addr", err_addr, 1'b0);
    reset = 1'b1;
  endtask

  // monitor: pops one expectation per rd_valid; otherwise rd_data must hold
  logic [DW-1:0] held = '0;
  bit            held_known = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!reset) begin
        held = '0;
        held_known = 1;
      end
      if (rd_valid) begin
        if (sb.size() == 0) begin
          chk("rd_valid_spurious", rd_valid, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (!e.dc) chk("rd_data", rd_data, e.data);
          held = e.data;
          held_known = !e.dc;
        end
      end else if (held_known) begin
        chk("rd_data_hold", rd_data, held);
      end
    end
  end

  initial begin
    model_reset();
    do_reset();
    idle(2);

    // 8-beat stream, lines 0..7 = A*0x11
    send_stream(8, 1, 0);
    idle(1);
    rd(5); rd(8); rd(0); rd(7);
    idle(2);

    // second stream fills the other buffer; a third overflows and is dropped
    send_stream(4, 1, 0);
    idle(1);
    send_stream(4, 1, 0);
    idle(1);
    rd(5); rd(3);
    idle(1);

    // release first buffer, read the 4-beat one
    step(0, 0, '0, '0, 0, '0, 1);
    idle(1);
    rd(2); rd(4);

    // stream into the freed buffer while releasing the serve buffer on eos
    for (int i = 0; i < 5; i++)
      step(i == 0, i == 4, XW'(4 - i), DW'(32'hA0 + i), 0, '0, i == 4);
    idle(1);
    rd(2); rd(4); rd(5);
    release_all();

    // single-beat stream at line 3
    step(1, 1, 8'd3, DW'(32'hBEEF), 0, '0, 0);
    idle(1);
    rd(3); rd(4); rd(0);
    release_all();

    // out-of-range address: stored at line 3, error flagged
    step(1, 0, 8'h00, DW'(32'h100), 0, '0, 0);
    step(0, 0, 8'h01, DW'(32'h101), 0, '0, 0);
    step(0, 0, 8'h02, DW'(32'h102), 0, '0, 0);
    step(0, 1, 8'h43, DW'(32'h143), 0, '0, 0);
    idle(1);
    rd(3); rd(1);
    release_all();

    // sos mid-stream restarts the count
    step(1, 0, 8'h00, DW'(32'h200), 0, '0, 0);
    step(0, 0, 8'h01, DW'(32'h201), 0, '0, 0);
    step(0, 0, 8'h02, DW'(32'h202), 0, '0, 0);
    step(1, 0, 8'h05, DW'(32'h205), 0, '0, 0);
    step(0, 1, 8'h06, DW'(32'h206), 0, '0, 0);
    idle(1);
    rd(0); rd(1); rd(2);
    release_all();

    // reset mid-stream; stray beats ignored; next stream captured normally
    send_stream(3, 1, 0);
    do_reset();
    step(0, 0, 8'h01, DW'(32'h301), 0, '0, 0);
    step(0, 1, 8'h02, DW'(32'h302), 0, '0, 0);
    idle(1);
    send_stream(6, 1, 0);
    idle(1);
    rd(4); rd(6);
    release_all();

    // saturation: 70 beats, later lines wrap by address
    send_stream(70, 1, 0);
    idle(1);
    rd(1); rd(63); rd(6);
    release_all();

    // randomized traffic with concurrent reads and releases
    for (int s = 0; s < 40; s++) begin
      send_stream($urandom_range(1, 9), 0, 1);
      for (int g = $urandom_range(0, 3); g > 0; g--)
        step(0, 0, '0, '0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)),
             $urandom_range(0, 7) == 0);
    end
    idle(4);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
